// File: rtl/ptp_a.sv
// Input parallel-to-parallel stage (type A): assembles MSB-first words from byte or bit
// chunks and holds each completed word under a valid/ack handshake.
module ptp_a #(
  parameter int WORD_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                   control_i,
  input  logic                   reset_ni,
  input  logic                   serialise_i,
  input  logic                   load_i,
  input  logic                   ack_i,
  input  logic                   clear_overrun_i,
  input  logic [CHUNK_WIDTH-1:0] value_i,
  output logic [WORD_WIDTH-1:0]  value_o,
  output logic                   valid_o,
  output logic                   overrun_o,
  output logic [5:0]             count_o
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [5:0] LAST_BYTE = 6'(WORD_WIDTH / CHUNK_WIDTH - 1);
  localparam logic [5:0] LAST_BIT  = 6'(WORD_WIDTH - 1);

  state_t                  state_q;
  logic                    mode_q;
  logic [WORD_WIDTH-1:0]   sr_q;
  logic [5:0]              count_q;
  logic [WORD_WIDTH-1:0]   value_q;
  logic                    valid_q;
  logic                    overrun_q;

  logic                    mode_chg_s;
  logic [WORD_WIDTH-1:0]   base_sr_s;
  logic [5:0]              base_cnt_s;
  logic [5:0]              last_idx_s;
  logic [WORD_WIDTH-1:0]   shifted_s;
  logic                    accept_s;
  logic                    last_s;
  logic [WORD_WIDTH-1:0]   sr_d;
  logic [5:0]              count_d;
  logic                    overrun_d;

  // Chunk acceptance, shift and count next-state; a mode change restarts the word
  always_comb begin
    mode_chg_s = (serialise_i != mode_q);
    base_sr_s  = {WORD_WIDTH{1'b0}};
    base_cnt_s = 6'd0;
    if (mode_chg_s) begin
      base_sr_s  = {WORD_WIDTH{1'b0}};
      base_cnt_s = 6'd0;
    end else begin
      base_sr_s  = sr_q;
      base_cnt_s = count_q;
    end

    if (serialise_i) begin
      last_idx_s = LAST_BIT;
      shifted_s  = {base_sr_s[WORD_WIDTH-2:0], value_i[0]};
    end else begin
      last_idx_s = LAST_BYTE;
      shifted_s  = {base_sr_s[WORD_WIDTH-CHUNK_WIDTH-1:0], value_i};
    end

    // In FULL a chunk is only taken when the held word is acknowledged on the same edge
    case (state_q)
      FILL:    accept_s = load_i;
      FULL:    accept_s = load_i & ack_i;
      default: accept_s = 1'b0;
    endcase

    last_s = accept_s & (base_cnt_s == last_idx_s);

    sr_d    = base_sr_s;
    count_d = base_cnt_s;
    if (accept_s) begin
      sr_d = shifted_s;
      if (last_s) begin
        count_d = 6'd0;
      end else begin
        count_d = base_cnt_s + 6'd1;
      end
    end else begin
      sr_d    = base_sr_s;
      count_d = base_cnt_s;
    end

    // Set beats clear when both land on the same edge
    if ((state_q == FULL) && load_i && !ack_i) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Handshake FSM and all state registers
  always_ff @(posedge control_i) begin
    if (!reset_ni) begin
      state_q   <= FILL;
      mode_q    <= serialise_i;
      sr_q      <= {WORD_WIDTH{1'b0}};
      count_q   <= 6'd0;
      value_q   <= {WORD_WIDTH{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      mode_q    <= serialise_i;
      sr_q      <= sr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      case (state_q)
        FILL: begin
          if (last_s) begin
            value_q <= shifted_s;
            valid_q <= 1'b1;
            state_q <= FULL;
          end else begin
            state_q <= FILL;
          end
        end
        FULL: begin
          if (ack_i) begin
            valid_q <= 1'b0;
            state_q <= FILL;
          end else begin
            state_q <= FULL;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= FILL;
        end
      endcase
    end
  end

  assign value_o   = value_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
  assign count_o   = count_q;

endmodule

// File: tb/tb_ptp_a.sv
// Bench for ptp_a: directed chunk sequences with a word scoreboard and status checks.
module tb_ptp_a;

  logic        clk;
  logic        reset_ni;
  logic        serialise_i;
  logic        load_i;
  logic        ack_i;
  logic        clear_overrun_i;
  logic [7:0]  value_i;
  logic [31:0] value_o;
  logic        valid_o;
  logic        overrun_o;
  logic [5:0]  count_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic        prev_valid = 1'b0;

  ptp_a dut (
    .control_i       (clk),
    .reset_ni        (reset_ni),
    .serialise_i     (serialise_i),
    .load_i          (load_i),
    .ack_i           (ack_i),
    .clear_overrun_i (clear_overrun_i),
    .value_i         (value_i),
    .value_o         (value_o),
    .valid_o         (valid_o),
    .overrun_o       (overrun_o),
    .count_o         (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic rst_n, input logic ser, input logic ld,
                      input logic ak, input logic clr, input logic [7:0] v);
    reset_ni        = rst_n;
    serialise_i     = ser;
    load_i          = ld;
    ack_i           = ak;
    clear_overrun_i = clr;
    value_i         = v;
    @(posedge clk);
    #1;
  endtask

  // Word monitor: each new valid word is compared against the head of the scoreboard
  always @(negedge clk) begin
    if (valid_o && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", value_o, 32'hxxxxxxxx);
      end else begin
        check("word", value_o, exp_q.pop_front());
      end
    end
    prev_valid = valid_o;
  end

  initial begin
    logic [31:0] pat;
    logic [7:0]  bytes4[4];

    // Reset
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_value", value_o, 32'h0);
    check("rst_valid", {31'b0, valid_o}, 32'h0);
    check("rst_overrun", {31'b0, overrun_o}, 32'h0);
    check("rst_count", {26'b0, count_o}, 32'h0);

    // Test 1: byte mode DEADBEEF
    exp_q.push_back(32'hDEADBEEF);
    bytes4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, bytes4[i]);
      check("t1_count", {26'b0, count_o}, (i + 1) % 4);
    end
    check("t1_valid", {31'b0, valid_o}, 32'h1);
    check("t1_value", value_o, 32'hDEADBEEF);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("t1_ack", {31'b0, valid_o}, 32'h0);

    // Test 2: bit mode CAFEB0BA, first bit on the mode-change edge
    exp_q.push_back(32'hCAFEB0BA);
    pat = 32'hCAFEB0BA;
    for (int i = 31; i >= 0; i--) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {7'h7F, pat[i]});
      check("t2_count", {26'b0, count_o}, (32 - i) % 32);
    end
    check("t2_valid", {31'b0, valid_o}, 32'h1);

    // Test 3: overrun while held (also a mode change back to byte mode)
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
    check("t3_overrun", {31'b0, overrun_o}, 32'h1);
    check("t3_value", value_o, 32'hCAFEB0BA);
    check("t3_count", {26'b0, count_o}, 32'h0);
    check("t3_valid", {31'b0, valid_o}, 32'h1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("t3_clear", {31'b0, overrun_o}, 32'h0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h66);
    check("t3_set_wins", {31'b0, overrun_o}, 32'h1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("t3_clear2", {31'b0, overrun_o}, 32'h0);

    // Test 4: ack and load on the same edge
    exp_q.push_back(32'h12345678);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12);
    check("t4_valid", {31'b0, valid_o}, 32'h0);
    check("t4_overrun", {31'b0, overrun_o}, 32'h0);
    check("t4_count", {26'b0, count_o}, 32'h1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h34);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h56);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h78);
    check("t4_value", value_o, 32'h12345678);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Test 5: mode change mid-word discards partial bytes
    exp_q.push_back(32'h80000000);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hBB);
    check("t5_count2", {26'b0, count_o}, 32'h2);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    check("t5_count_mc", {26'b0, count_o}, 32'h1);
    for (int i = 0; i < 31; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    check("t5_value", value_o, 32'h80000000);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    // Test 6: reset mid-word, reset while held with overrun, then a fresh word
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44);
    check("t6_rst_count", {26'b0, count_o}, 32'h0);
    check("t6_rst_valid", {31'b0, valid_o}, 32'h0);
    exp_q.push_back(32'h0A0B0C0D);
    bytes4 = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, bytes4[i]);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hEE);
    check("t6_overrun", {31'b0, overrun_o}, 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_rst2_value", value_o, 32'h0);
    check("t6_rst2_valid", {31'b0, valid_o}, 32'h0);
    check("t6_rst2_overrun", {31'b0, overrun_o}, 32'h0);
    exp_q.push_back(32'h01020304);
    bytes4 = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, bytes4[i]);
    check("t6_value", value_o, 32'h01020304);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ptp_a.md
Name: ptp_a

Overview:
- Input-side parallel-to-parallel stage, type A. Sits between the 8-bit TT input pins and the Manchester Baby.
- Assembles 32-bit words from byte or bit chunks, MSB first, and holds each word on value_o with a valid/ack handshake until the Baby consumes it.
- value_o is also the word that the output stage mirrors in debug mode.

Parameters:
- WORD_WIDTH, 32, assembled word width; must be a multiple of 8.
- CHUNK_WIDTH, 8, input pin width in byte mode.

Ports:
- control_i  input  1  clock; all state updates on its rising edge.
- reset_ni  input  1  synchronous, active-low reset.
- serialise_i  input  1  mode select: 1 = bit mode (value_i[0] only), 0 = byte mode.
- load_i  input  1  chunk strobe; value_i is sampled when high.
- ack_i  input  1  consumer acknowledge of the held word.
- clear_overrun_i  input  1  clears overrun_o.
- value_i  input  8  input chunk.
- value_o  output  32  last completed word.
- valid_o  output  1  value_o holds an unacknowledged word.
- overrun_o  output  1  sticky: a chunk arrived while a word was held.
- count_o  output  6  chunks received into the current partial word.

Behaviour:
- Reset (reset_ni low at a rising edge of control_i):
  - value_o = 0, valid_o = 0, overrun_o = 0, count_o = 0.
  - Shift register = 0, state = FILL, mode_q = serialise_i.
  - Reset has priority over every other input.
  - Reset mid-word discards the partial word.
- Chunks per word: byte mode 4 (WORD_WIDTH/8), bit mode 32 (WORD_WIDTH).
- Shift register update:
  - Byte mode: sr <= {sr[23:0], value_i}.
  - Bit mode: sr <= {sr[30:0], value_i[0]}.
  - The first chunk received lands in the MSBs of the completed word.
- State FILL:
  - load_i = 1 shifts the chunk in and increments count.
  - On the last chunk (count = N-1 with load_i = 1):
    - value_o <= completed word, including this chunk, on that same edge.
    - valid_o <= 1, count <= 0, state <= FULL.
    - Latency is 0 cycles: value_o and valid_o are visible right after the edge that samples the last chunk.
  - ack_i in FILL is ignored.
- State FULL:
  - valid_o = 1 and value_o is stable.
  - ack_i = 1: valid_o <= 0 and state <= FILL.
  - load_i = 1 with ack_i = 0: chunk dropped, overrun_o <= 1, sr and count unchanged.
  - ack_i = 1 and load_i = 1 on the same edge: ack is taken, and the chunk is accepted as chunk 0 of the next word (count <= 1). No overrun is flagged.
- Mode change (serialise_i != mode_q at an edge):
  - mode_q <= serialise_i, count <= 0, sr <= 0. The partial word is discarded.
  - If load_i is also high, the chunk is taken as chunk 0 in the new mode (count <= 1).
  - In FULL, valid_o and value_o are unaffected.
  - In FULL, a chunk arriving on the mode-change edge is still an overrun unless ack_i is also high.
- Overrun flag:
  - clear_overrun_i = 1 clears overrun_o.
  - If clear and a set condition occur on the same edge, set wins.
- count_o:
  - Shows the registered count, range 0..N-1.
  - Never shows N; it wraps to 0 on word completion.
- value_o is only updated on word completion and is never glitched by partial shifting.

Test Plan:
1. Reset, then byte mode, load 0xDE, 0xAD, 0xBE, 0xEF on 4 consecutive edges -> after the 4th edge value_o = 0xDEADBEEF, valid_o = 1, count_o = 0; ack -> valid_o = 0.
2. Bit mode, 32 loads of value_i[0] from pattern 0xCAFEB0BA (MSB first), value_i[7:1] = 1s -> value_o = 0xCAFEB0BA, valid_o = 1; count_o steps 0..31 then wraps to 0.
3. Word held, no ack, load 0x55 -> overrun_o = 1, value_o unchanged, count_o = 0; assert clear_overrun_i -> overrun_o = 0; clear and overrun on the same edge -> overrun_o stays 1.
4. Word held, ack_i and load_i = 0x12 on the same edge -> valid_o = 0, overrun_o = 0, count_o = 1; then load 0x34, 0x56, 0x78 -> value_o = 0x12345678.
5. Byte mode after 2 bytes (0xAA, 0xBB), toggle serialise_i to 1 with load_i = 1, value_i[0] = 1 -> count_o = 1; 31 more zero bits -> value_o = 0x80000000.
6. Assert reset_ni low for 1 cycle after 3 bytes, or while valid_o = 1 -> all outputs 0 on the next edge; then 4 fresh bytes 0x01, 0x02, 0x03, 0x04 -> value_o = 0x01020304.
